// File: rtl/seg_ctrl_pkg.sv
// Shared types and sizes for the seven-segment serial display path.
package seg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seg_state_t;

  localparam int SEG_DIGITS = 8;
  localparam int SEG_BITS   = SEG_DIGITS * 8;

endpackage

// File: rtl/seg_flash_gen.sv
// Free-running blink counter; flash is the registered counter MSB.
// Latency: flash tracks counter[FLASH_W-1] with no extra delay.
// Backpressure: none, runs every clk cycle.
module seg_flash_gen #(
  parameter int FLASH_W = 24
) (
  input  logic clk,
  input  logic rst,
  output logic flash
);

  logic [FLASH_W-1:0] cnt;
  logic [FLASH_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt + FLASH_W'(1);

  // flash takes the MSB of the incremented value so it equals the current count MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      flash <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      flash <= cnt_nxt[FLASH_W-1];
    end
  end

endmodule

// File: rtl/seg_serial_ctrl.sv
// Shifts the 64-bit segment pattern MSB first to the external chain and makes the blink strobe.
// Latency: done pulses 128*CLK_DIV+1 cycles after the start edge.
// Backpressure: start during a transfer is remembered as one rerun; seg_data is sampled only at load.
module seg_serial_ctrl
  import seg_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int FLASH_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_pen,
  output logic        seg_clrn,
  output logic        flash
);

  localparam int             PW       = $clog2(CLK_DIV) + 1;
  localparam logic [PW-1:0]  PH_RISE  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]  PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [6:0]     BIT_LAST = 7'(SEG_BITS - 1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("seg_serial_ctrl: CLK_DIV must be 1 or more");
  end

  seg_state_t          state;
  logic [SEG_BITS-2:0] shreg;
  logic [6:0]          bit_cnt;
  logic [PW-1:0]       phase;
  logic                pending;
  logic                load;

  // A rerun is taken straight out of DONE, so pending never survives into IDLE.
  assign load = ((state == IDLE) && start) ||
                ((state == DONE) && (pending || start));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      phase    <= '0;
      pending  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      seg_clk  <= 1'b0;
      seg_sout <= 1'b0;
      seg_pen  <= 1'b0;
      seg_clrn <= 1'b0;
    end else begin
      seg_clrn <= 1'b1;
      done     <= 1'b0;
      if (load) begin
        state    <= SHIFT;
        shreg    <= seg_data[SEG_BITS-2:0];
        seg_sout <= seg_data[SEG_BITS-1];
        bit_cnt  <= '0;
        phase    <= '0;
        pending  <= 1'b0;
        busy     <= 1'b1;
        seg_clk  <= 1'b0;
        seg_pen  <= 1'b0;
      end else begin
        case (state)
          SHIFT: begin
            if (start) pending <= 1'b1;
            // Data moves only as seg_clk falls, giving CLK_DIV cycles of setup.
            if (phase == PH_LAST) begin
              phase    <= '0;
              seg_clk  <= 1'b0;
              seg_sout <= shreg[SEG_BITS-2];
              shreg    <= {shreg[SEG_BITS-3:0], 1'b0};
              bit_cnt  <= bit_cnt + 7'd1;
              if (bit_cnt == BIT_LAST) begin
                state   <= DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
                seg_pen <= 1'b1;
              end
            end else begin
              phase <= phase + PW'(1);
              if (phase == PH_RISE) seg_clk <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  seg_flash_gen #(
    .FLASH_W(FLASH_W)
  ) u_flash (
    .clk  (clk),
    .rst  (rst),
    .flash(flash)
  );

endmodule

// File: tb/tb_seg_serial_ctrl.sv
// Directed bench: two controllers (CLK_DIV=2 and CLK_DIV=1), both with a 4-bit blink counter.
module tb_seg_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [63:0] data0 = '0, data1 = '0;
  logic        busy0, done0, sclk0, sout0, pen0, clrn0, flash0;
  logic        busy1, done1, sclk1, sout1, pen1, clrn1, flash1;

  always #5 clk = ~clk;

  seg_serial_ctrl #(.CLK_DIV(2), .FLASH_W(4)) dut0 (
    .clk(clk), .rst(rst), .seg_data(data0), .start(start0),
    .busy(busy0), .done(done0), .seg_clk(sclk0), .seg_sout(sout0),
    .seg_pen(pen0), .seg_clrn(clrn0), .flash(flash0)
  );

  seg_serial_ctrl #(.CLK_DIV(1), .FLASH_W(4)) dut1 (
    .clk(clk), .rst(rst), .seg_data(data1), .start(start1),
    .busy(busy1), .done(done1), .seg_clk(sclk1), .seg_sout(sout1),
    .seg_pen(pen1), .seg_clrn(clrn1), .flash(flash1)
  );

  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          rise0 = 0, rise1 = 0, dcnt0 = 0, dcnt1 = 0, unstable1 = 0;
  logic [63:0] cap0 = '0, cap1 = '0;
  logic        last_sout1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge sclk0) begin
    cap0  <= {cap0[62:0], sout0};
    rise0 <= rise0 + 1;
  end

  always @(posedge sclk1) begin
    cap1  <= {cap1[62:0], sout1};
    rise1 <= rise1 + 1;
    if (sout1 !== last_sout1) unstable1 <= unstable1 + 1;
  end

  always @(negedge clk) begin
    last_sout1 <= sout1;
    if (done0 === 1'b1) dcnt0 <= dcnt0 + 1;
    if (done1 === 1'b1) dcnt1 <= dcnt1 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic flash_exp(input int since_rel);
    return logic'((since_rel >> 3) & 1);
  endfunction

  task automatic wait_done(input bit which, output int dcyc, output logic ok);
    ok   = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ((which ? done1 : done0) === 1'b1) begin
        ok   = 1'b1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  initial begin
    int   c, dcyc, rb, dc, rel;
    logic ok;

    // Reset state
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_clrn",  clrn0, 0);
    chk("rst_busy",  busy0, 0);
    chk("rst_pen",   pen0,  0);
    chk("rst_sclk",  sclk0, 0);
    chk("rst_sout",  sout0, 0);
    chk("rst_done",  done0, 0);
    chk("rst_flash", flash0, 0);

    // Release: clrn rises one edge later, flash period 16, idle stays quiet
    rst = 1'b0;
    rel = cyc;
    rb  = rise0;
    chk("rel_clrn", clrn0, 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) chk("clrn_up", clrn0, 1);
      chk("flash_seq", flash0, flash_exp(cyc - rel));
    end
    chk("flash_c16", flash0, 0);
    chk("idle_busy", busy0, 0);
    chk("idle_pen",  pen0, 0);
    chk("idle_sclk_edges", rise0 - rb, 0);

    // CLK_DIV=2 transfer
    rb = rise0; dc = dcnt0;
    data0 = 64'hC0F9_A4B0_9992_82F8; start0 = 1'b1; c = cyc;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_n1",  busy0, 1);
    chk("pen_shift", pen0, 0);
    wait_done(1'b0, dcyc, ok);
    chk("d2_done_seen",  ok, 1);
    chk("d2_done_cycle", dcyc, c + 257);
    chk("d2_done_busy",  busy0, 0);
    chk("d2_done_pen",   pen0, 1);
    chk("d2_done_sclk",  sclk0, 0);
    chk("d2_rises",      rise0 - rb, 64);
    chk("d2_bits",       cap0, 64'hC0F9_A4B0_9992_82F8);
    chk("d2_flash",      flash0, flash_exp(cyc - rel));
    @(negedge clk);
    chk("d2_done_once",  done0, 0);
    chk("d2_pen_hold",   pen0, 1);
    chk("d2_idle_busy",  busy0, 0);
    chk("d2_done_count", dcnt0 - dc, 1);

    // CLK_DIV=1 transfer with alternating bits
    rb = rise1; dc = dcnt1;
    data1 = 64'hAAAA_AAAA_AAAA_AAAA; start1 = 1'b1; c = cyc;
    @(negedge clk);
    start1 = 1'b0;
    chk("d1_busy_n1", busy1, 1);
    wait_done(1'b1, dcyc, ok);
    chk("d1_done_seen",  ok, 1);
    chk("d1_done_cycle", dcyc, c + 129);
    chk("d1_rises",      rise1 - rb, 64);
    chk("d1_bits",       cap1, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("d1_sout_stable", unstable1, 0);
    chk("d1_done_pen",   pen1, 1);
    @(negedge clk);
    chk("d1_done_count", dcnt1 - dc, 1);

    // Restart during SHIFT with data changed after load
    rb = rise0; dc = dcnt0;
    data0 = 64'hF0E1_D2C3_B4A5_9687; start0 = 1'b1; c = cyc;
    @(negedge clk);
    start0 = 1'b0; data0 = 64'h0;
    repeat (100) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (40) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(1'b0, dcyc, ok);
    chk("rr_done1_seen",  ok, 1);
    chk("rr_done1_cycle", dcyc, c + 257);
    chk("rr_bits1",       cap0, 64'hF0E1_D2C3_B4A5_9687);
    chk("rr_rises1",      rise0 - rb, 64);
    @(negedge clk);
    chk("rr_rerun_busy", busy0, 1);
    chk("rr_rerun_pen",  pen0, 0);
    chk("rr_rerun_done", done0, 0);
    wait_done(1'b0, dcyc, ok);
    chk("rr_done2_seen",  ok, 1);
    chk("rr_done2_cycle", dcyc, c + 514);
    chk("rr_bits2",       cap0, 64'h0);
    repeat (10) @(negedge clk);
    chk("rr_idle_busy",  busy0, 0);
    chk("rr_idle_pen",   pen0, 1);
    chk("rr_done_count", dcnt0 - dc, 2);
    chk("rr_rises_tot",  rise0 - rb, 128);

    // Reset while bit 30 is on the wire
    rb = rise0; dc = dcnt0;
    data0 = 64'hC0F9_A4B0_9992_82F8; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((rise0 - rb) == 31 && sclk0 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ab_reach_bit30", ok, 1);
    #1 rst = 1'b1;
    #1;
    chk("ab_busy", busy0, 0);
    chk("ab_sclk", sclk0, 0);
    chk("ab_pen",  pen0, 0);
    chk("ab_done", done0, 0);
    chk("ab_clrn", clrn0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    chk("ab_no_done",   dcnt0 - dc, 0);
    chk("ab_pen_after", pen0, 0);
    chk("ab_busy_after", busy0, 0);
    chk("ab_clrn_after", clrn0, 1);
    chk("ab_flash_rst",  flash0, flash_exp(cyc - rel));

    // Fresh transfer after the abort
    rb = rise0;
    data0 = 64'h0123_4567_89AB_CDEF; start0 = 1'b1; c = cyc;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(1'b0, dcyc, ok);
    chk("pa_done_seen",  ok, 1);
    chk("pa_done_cycle", dcyc, c + 257);
    chk("pa_bits",       cap0, 64'h0123_4567_89AB_CDEF);
    chk("pa_rises",      rise0 - rb, 64);
    chk("pa_pen",        pen0, 1);
    chk("pa_flash",      flash0, flash_exp(cyc - rel));
    chk("pa_flash_d1",   flash1, flash_exp(cyc - rel));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seg_serial_ctrl.md
Name: seg_serial_ctrl

Overview:
- Sequences the 8-digit seven-segment display path.
- Takes the 64-bit segment pattern produced by the hex-to-segment encoder and shifts it out serially to the board's external shift-register chain.
- Pulses a done handshake when the transfer finishes.
- Generates the free-running blink (flash) strobe that feeds the encoder's flash input.

Parameters:
- CLK_DIV, 2: clk cycles per seg_clk half-period. Legal range is 1 or more; values below 1 are illegal.
- FLASH_W, 24: width of the blink counter. flash is the counter MSB and toggles every 2^(FLASH_W-1) cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- seg_data  input  64  segment pattern; [63:56] is digit 0, bit order {a,b,c,d,e,f,g,p} per byte
- start  input  1  request a transfer; single-cycle pulse or level
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse when a transfer completes
- seg_clk  output  1  serial shift clock to the external chain
- seg_sout  output  1  serial data, valid around the seg_clk rising edge
- seg_pen  output  1  display output enable; 0 blanks the display
- seg_clrn  output  1  active-low clear to the external chain
- flash  output  1  blink strobe to the encoder

Behaviour:
- Reset values while rst=1 (asynchronous): state=IDLE, busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, flash=0, pending=0, blink counter=0.
- seg_clrn goes to 1 on the first clk edge after rst deasserts and stays 1.
- Reset mid-transfer aborts the transfer immediately. No done pulse is issued. seg_pen stays 0 until a later transfer completes.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge N loads shreg<=seg_data, sets bit_cnt=0 and phase=0, drives seg_sout<=seg_data[63], and moves to SHIFT.
  - busy=1 from cycle N+1.
- SHIFT, for each of the 64 bits:
  - seg_clk=0 for CLK_DIV cycles, then seg_clk=1 for CLK_DIV cycles.
  - At the end of the high phase: shreg shifts left by 1, seg_sout takes the next bit, bit_cnt increments.
  - seg_sout changes only while seg_clk is falling or low. This gives a setup of at least CLK_DIV cycles before each rising edge.
  - seg_pen=0 throughout SHIFT.
  - After the 64th high phase, go to DONE. SHIFT lasts exactly 128*CLK_DIV cycles. Bits are sent MSB first, seg_data[63] first and seg_data[0] last.
- DONE (one cycle):
  - done=1, busy=0, seg_clk=0, seg_pen=1.
  - If start=1 at edge N, done is high in cycle N+128*CLK_DIV+1.
  - If pending=1, the next state is SHIFT with a reload from the current seg_data, pending clears, and busy returns to 1 in the following cycle.
  - Otherwise the next state is IDLE.
- Pending and start rules:
  - start=1 while in SHIFT or DONE sets pending. Multiple starts collapse into one rerun.
  - start in IDLE does not set pending.
  - start while busy never corrupts the transfer in flight. seg_data is sampled only at load.
- seg_pen: once set to 1 it holds 1 in IDLE and returns to 0 on entry to SHIFT.
- Blink counter:
  - Free-running, increments every clk cycle and wraps modulo 2^FLASH_W.
  - flash = counter[FLASH_W-1], registered.
  - Unaffected by transfer state.
- bit_cnt is 7 bits wide; its terminal value is 63 at the end of the high phase. The phase counter width is clog2(CLK_DIV)+1.

Decomposition:
- Shared package seg_ctrl_pkg holds:
  - the state enum {IDLE, SHIFT, DONE}
  - constant SEG_BITS=64
  - constant SEG_DIGITS=8
- One natural sub-module, seg_flash_gen: the FLASH_W blink counter with clk/rst and flash output.
- Everything else stays in seg_serial_ctrl.

Test Plan:
- Reset, then idle with CLK_DIV=2 -> seg_clrn=0 during rst and 1 one cycle after release; busy=0, seg_pen=0, seg_clk=0; no seg_clk edges occur.
- start pulse at edge N with seg_data=64'hC0F9_A4B0_9992_82F8 -> busy high from N+1; exactly 64 seg_clk rising edges; bits captured at the rising edges equal seg_data MSB first; done=1 only at N+257, with busy=0 and seg_pen=1 in that cycle.
- CLK_DIV=1 with alternating pattern 64'hAAAA_AAAA_AAAA_AAAA -> seg_clk period 2 cycles; seg_sout stable across every rising edge; done at N+129.
- start re-asserted mid-SHIFT, with seg_data changed to 64'h0 after the first load -> first transfer shifts the original pattern; one done pulse; immediate second transfer shifts all zeros; second done; then IDLE.
- rst asserted at bit 30 of a transfer -> same cycle: busy=0, seg_clk=0, seg_pen=0, no done; after release, a new start completes normally.
- FLASH_W=4 -> flash=0 for cycles 0-7 after reset, 1 for cycles 8-15, period 16 cycles, independent of transfers.
